page_param_loader: RTL

PAGE_PARAM_LOADER -- requirements
Module: page_param_loader

---
 rtl/page_param_loader_if.sv | 36 +++
 rtl/page_param_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/page_param_loader_if.sv
// page_param_loader_if: bundles the load-request, byte-stream and readback
// signals of the page parameter loader.
//   start/base_idx/length : load request (master -> slave)
//   in_valid/in_data      : upstream byte stream (master -> slave)
//   in_ready              : byte acceptance (slave -> master)
//   busy/done/err/checksum: load status (slave -> master)
//   rd_en/rd_idx          : readback request (master -> slave)
//   rd_data/rd_valid      : readback response (slave -> master)
interface page_param_loader_if #(
  parameter int IDX_W = 17
);
  logic             start;
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] length;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [15:0]      checksum;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             rd_valid;

  modport master (
    output start, base_idx, length, in_valid, in_data, rd_en, rd_idx,
    input  in_ready, busy, done, err, checksum, rd_data, rd_valid
  );

  modport slave (
    input  start, base_idx, length, in_valid, in_data, rd_en, rd_idx,
    output in_ready, busy, done, err, checksum, rd_data, rd_valid
  );
endinterface

// File: rtl/page_param_loader.sv
// page_param_loader: loads a run of bytes from an upstream stream into a
// DEPTH x 8 page parameter RAM starting at base_idx, keeps a 16-bit running
// checksum of the load, and offers an independent synchronous readback port.
// Ports:
//   hw_clk : single clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : page_param_loader_if slave modport (request, stream, status,
//            readback)
module page_param_loader #(
  parameter int DEPTH = 20551,
  parameter int IDX_W = 17
) (
  input  logic                 hw_clk,
  input  logic                 rst,
  page_param_loader_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] remain_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      checksum_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;

  logic [7:0]       mem [DEPTH];

  logic             accept;
  logic [IDX_W:0]   end_idx;
  logic             rd_in_range;

  function automatic logic [15:0] csum_add(input logic [15:0] sum,
                                           input logic [7:0]  b);
    return sum + {8'h00, b};
  endfunction

  assign accept      = in_ready_q & bus.in_valid;
  // One extra bit so base+length cannot wrap past the range check.
  assign end_idx     = {1'b0, bus.base_idx} + {1'b0, bus.length};
  assign rd_in_range = ({1'b0, bus.rd_idx} < (IDX_W+1)'(DEPTH));

  // Control FSM with registered status outputs
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      remain_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      checksum_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.length == '0) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else if (end_idx > (IDX_W+1)'(DEPTH)) begin
              // Rejected load: no pointer update, nothing is written.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              wr_ptr_q   <= bus.base_idx;
              remain_q   <= bus.length;
              checksum_q <= '0;
              err_q      <= 1'b0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            remain_q   <= remain_q - 1'b1;
            checksum_q <= csum_add(checksum_q, bus.in_data);
            if (remain_q == IDX_W'(1)) begin
              // Drop in_ready on the same edge so no extra byte slips in.
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FIN;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM write port; storage carries no reset so it maps onto block RAM.
  // The range check at start guarantees wr_ptr_q < DEPTH here.
  always_ff @(posedge hw_clk) begin
    if (accept && !rst) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end
  end

  // RAM read port: read-first against a same-cycle write, out-of-range
  // indices return zero, data holds while rd_en is low.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_in_range ? mem[bus.rd_idx[AW-1:0]] : 8'h00;
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.checksum = checksum_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
